fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 123 ++++++++++++
 tb/tb_fetch_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC/fetch-address registers, a three-state request FSM
// and a 2-entry {instr, pc} buffer feeding decode.
module fetch_controller #(
  parameter int                     PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                out_valid,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  input  logic                out_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc, pc_nxt, fetch_addr, addr_nxt, pc_inc;
  entry_t [1:0]          fifo;
  logic [1:0]            count, count_after, wr_idx;
  logic                  pop, push, slot_free;

  // A redirect cancels both sides of the buffer in the same cycle.
  assign pop         = out_valid & out_ready & ~redirect;
  assign push        = (state == FETCH) & imem_ack & ~redirect;
  assign count_after = count - {1'b0, pop} + {1'b0, push};
  assign slot_free   = (count_after != 2'd2);
  assign wr_idx      = count - {1'b0, pop};
  assign pc_inc      = fetch_addr + PC_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetch_addr <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = fetch_addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
          if (!halt) begin
            state_nxt = FETCH;
            addr_nxt  = redirect_pc;
          end
        end else if (!halt && slot_free) begin
          state_nxt = FETCH;
          addr_nxt  = pc;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt    = redirect_pc;
            addr_nxt  = redirect_pc;
            state_nxt = halt ? IDLE : FETCH;
          end else begin
            pc_nxt    = pc_inc;
            addr_nxt  = pc_inc;
            state_nxt = (!halt && slot_free) ? FETCH : IDLE;
          end
        end else if (redirect) begin
          // Old address stays on the bus until the memory acks it.
          pc_nxt    = redirect_pc;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (redirect) pc_nxt = redirect_pc;
        if (imem_ack) begin
          addr_nxt  = redirect ? redirect_pc : pc;
          state_nxt = halt ? IDLE : FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state != IDLE);
  end

  assign imem_addr = fetch_addr;
  assign out_valid = (count != 2'd0);
  assign out_instr = fifo[0].instr;
  assign out_pc    = fifo[0].pc;

  // Shift buffer: slot 0 is always the head, so outputs only move on a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      fifo  <= '0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      count <= count_after;
      if (pop)  fifo[0] <= fifo[1];
      if (push) fifo[wr_idx[0]] <= '{instr: imem_rdata, pc: imem_addr};
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed + random bench for fetch_controller; expected fetch/decode streams come from
// a sequential-program reference model (addresses count up, jump on redirect).
module tb_fetch_controller;
  localparam int          PC_WIDTH = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset, halt, redirect, imem_req, imem_ack, out_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_instr, out_pc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] fetch_exp, out_exp;
  logic        flushing;
  logic        p_req, p_ack, p_halt, p_valid, p_rdy, p_rd;
  logic [31:0] p_addr, p_pc, p_instr;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a * 32'h9E3779B9 + 32'h01234567;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  fetch_controller #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    reset = 1'b0;
    fetch_exp = RESET_PC; out_exp = RESET_PC; flushing = 1'b0;
    p_req = 0; p_ack = 0; p_halt = 0; p_valid = 0; p_rdy = 0; p_rd = 0;
    p_addr = '0; p_pc = '0; p_instr = '0;
  endtask

  // One clock cycle: drive inputs, then compare DUT against the program-order model.
  task automatic step(input logic h, input logic rd, input logic [31:0] rpc,
                      input logic ack, input logic rdy);
    @(negedge clk);
    halt = h; redirect = rd; redirect_pc = rpc; imem_ack = ack; out_ready = rdy;
    #1;
    if (p_req && !p_ack) begin
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, p_addr);
    end else if (p_halt) begin
      chk("halt_no_req", {31'b0, imem_req}, 32'd0);
    end
    if (p_rd) chk("flush_empty", {31'b0, out_valid}, 32'd0);
    else if (p_valid && !p_rdy) begin
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_pc", out_pc, p_pc);
      chk("stall_instr", out_instr, p_instr);
    end
    if (imem_req && imem_ack && !flushing && !rd) begin
      chk("fetch_addr", imem_addr, fetch_exp);
      fetch_exp = fetch_exp + 1;
    end
    if (!rd && out_valid && out_ready) begin
      chk("out_pc", out_pc, out_exp);
      chk("out_instr", out_instr, mem_f(out_exp));
      out_exp = out_exp + 1;
    end
    if (rd) begin
      fetch_exp = rpc; out_exp = rpc;
      flushing  = imem_req && !imem_ack;
    end else if (imem_req && imem_ack) flushing = 1'b0;
    p_req = imem_req; p_ack = imem_ack; p_halt = h; p_rd = rd;
    p_valid = out_valid; p_rdy = rdy; p_addr = imem_addr; p_pc = out_pc; p_instr = out_instr;
  endtask

  initial begin
    // Streaming with ack and ready tied high
    do_reset();
    step(0, 0, 0, 1, 1);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 1);
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_pc", out_pc, i);
    end

    // Backpressure fills both slots, then fetching resumes at pc 2
    do_reset();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_head", out_pc, 32'd0);
    step(0, 0, 0, 1, 0);
    chk("full_req2", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 1, 1);
    chk("drain_head", out_pc, 32'd0);
    step(0, 0, 0, 1, 1);
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'd2);
    chk("second_head", out_pc, 32'd1);

    // Redirect while waiting for ack at addr 3
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h40, 0, 1);
    chk("flush_at3", imem_addr, 32'd3);
    step(0, 0, 0, 0, 1);
    chk("flush_req", {31'b0, imem_req}, 32'd1);
    chk("flush_addr", imem_addr, 32'd3);
    step(0, 0, 0, 1, 1);
    chk("flush_ack_addr", imem_addr, 32'd3);
    step(0, 0, 0, 0, 1);
    chk("post_flush_addr", imem_addr, 32'h40);
    chk("post_flush_empty", {31'b0, out_valid}, 32'd0);

    // Redirect coincident with ack at addr 5
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h10, 1, 1);
    chk("rd_ack_at5", imem_addr, 32'd5);
    step(0, 0, 0, 1, 1);
    chk("rd_ack_next", imem_addr, 32'h10);
    chk("rd_ack_empty", {31'b0, out_valid}, 32'd0);
    step(0, 0, 0, 1, 1);
    chk("rd_ack_head", out_pc, 32'h10);

    // Halt lets the outstanding request finish, then resumes sequentially
    do_reset();
    step(1, 0, 0, 0, 1);
    chk("halt_outstanding", {31'b0, imem_req}, 32'd1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    chk("halt_idle", {31'b0, imem_req}, 32'd0);
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("unhalt_req", {31'b0, imem_req}, 32'd1);
    chk("unhalt_addr", imem_addr, 32'd1);

    // PC wraps at the top of the address space
    do_reset();
    step(0, 1, 32'hFFFF_FFFF, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFF);
    step(0, 0, 0, 1, 1);
    chk("wrap_zero", imem_addr, 32'h0);

    // Reset in the middle of an outstanding request
    do_reset();
    step(0, 0, 0, 0, 1);
    chk("pre_abort_req", {31'b0, imem_req}, 32'd1);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      if (n % 700 == 699) do_reset();
      rpc = ($urandom % 4 == 0) ? 32'hFFFF_FFFE + ($urandom % 4) : $urandom;
      step($urandom % 8 == 0, $urandom % 16 == 0, rpc, $urandom % 3 != 0, $urandom % 4 != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
